// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants for the 4:1 lane mux built from 2:1 muxes
package mux_pkg;

    // Lane select encodings
    localparam logic [1:0] SEL_L0 = 2'b00;
    localparam logic [1:0] SEL_L1 = 2'b01;
    localparam logic [1:0] SEL_L2 = 2'b10;
    localparam logic [1:0] SEL_L3 = 2'b11;

    localparam int NUM_LANES = 4;
    localparam int CNT_W     = 8;

endpackage

// File: rtl/mux_2to1.sv
// rtl/mux_2to1.sv - parameterised 2:1 multiplexer leaf cell
//   d0, d1 : data inputs, DATA_W bits
//   s      : select, 1 picks d1
//   y      : selected data, DATA_W bits
module mux_2to1 #(
    parameter int DATA_W = 1
) (
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    input  logic              s,
    output logic [DATA_W-1:0] y
);

    assign y = s ? d1 : d0;

endmodule

// File: rtl/mux_4to1_using_2to1.sv
// rtl/mux_4to1_using_2to1.sv - 4:1 lane mux as a tree of three 2:1 muxes, plus registered copy
//   clk     : sole clock, rising edge
//   rst_n   : synchronous active-low reset, clears y_q (and chg_cnt)
//   a       : four lanes, lane k at a[k*DATA_W +: DATA_W]
//   sel     : lane select
//   y       : combinational selected lane
//   y_q     : y registered one cycle later
//   chg_cnt : saturating count of y_q changes (only with MUX_CHANGE_CNT_EN)
module mux_4to1_using_2to1
    import mux_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_LANES*DATA_W-1:0] a,
    input  logic [1:0]                  sel,
    output logic [DATA_W-1:0]           y,
    output logic [DATA_W-1:0]           y_q
`ifdef MUX_CHANGE_CNT_EN
    ,
    output logic [CNT_W-1:0]            chg_cnt
`endif
);

    logic [DATA_W-1:0] lane [NUM_LANES];
    logic [DATA_W-1:0] m0;
    logic [DATA_W-1:0] m1;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign lane[k] = a[k*DATA_W +: DATA_W];
    end

    // Level 1: sel[0] picks within each pair of lanes
    mux_2to1 #(.DATA_W(DATA_W)) u_mux_lo (
        .d0 (lane[0]),
        .d1 (lane[1]),
        .s  (sel[0]),
        .y  (m0)
    );

    mux_2to1 #(.DATA_W(DATA_W)) u_mux_hi (
        .d0 (lane[2]),
        .d1 (lane[3]),
        .s  (sel[0]),
        .y  (m1)
    );

    // Level 2: sel[1] picks between the pairs
    mux_2to1 #(.DATA_W(DATA_W)) u_mux_out (
        .d0 (m0),
        .d1 (m1),
        .s  (sel[1]),
        .y  (y)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q <= '0;
        end else begin
            y_q <= y;
        end
    end

`ifdef MUX_CHANGE_CNT_EN
    // y is the value y_q is about to take, so y != y_q means y_q changes at this edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chg_cnt <= '0;
        end else if ((y != y_q) && (chg_cnt != {CNT_W{1'b1}})) begin
            chg_cnt <= chg_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_4to1_using_2to1.sv
// tb/tb_mux_4to1_using_2to1.sv - self-checking bench for mux_4to1_using_2to1 (DATA_W=1 and DATA_W=8)
module tb_mux_4to1_using_2to1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  a1;
    logic [1:0]  sel1;
    logic [0:0]  y1, y_q1;
    logic [31:0] a8;
    logic [1:0]  sel8;
    logic [7:0]  y8, y_q8;
`ifdef MUX_CHANGE_CNT_EN
    logic [7:0]  cnt1, cnt8;
`endif

    int checks = 0;
    int errors = 0;

    // model state
    logic [0:0] my1;
    logic [7:0] my8;
    int         mc1;

    always #5 clk = ~clk;

    mux_4to1_using_2to1 #(.DATA_W(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a1),
        .sel     (sel1),
        .y       (y1),
        .y_q     (y_q1)
`ifdef MUX_CHANGE_CNT_EN
        ,
        .chg_cnt (cnt1)
`endif
    );

    mux_4to1_using_2to1 #(.DATA_W(8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a8),
        .sel     (sel8),
        .y       (y8),
        .y_q     (y_q8)
`ifdef MUX_CHANGE_CNT_EN
        ,
        .chg_cnt (cnt8)
`endif
    );

    // Reference: split the bus into an array of lanes and index it by sel
    function automatic logic [31:0] pick(input logic [63:0] a, input int w, input logic [1:0] s);
        logic [31:0] lanes [4];
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        for (int k = 0; k < 4; k++) lanes[k] = 32'((a >> (k * w)) & mask);
        return lanes[s];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_y(input string tag);
        #1;
        check({tag, "_y1"}, 32'(y1), pick(64'(a1), 1, sel1));
        check({tag, "_y8"}, 32'(y8), pick(64'(a8), 8, sel8));
    endtask

    // One rising edge: predict y_q from inputs before the edge, compare after
    task automatic tick(input string tag);
        logic [0:0] n1;
        logic [7:0] n8;
        n1 = rst_n ? 1'(pick(64'(a1), 1, sel1)) : 1'b0;
        n8 = rst_n ? 8'(pick(64'(a8), 8, sel8)) : 8'h00;
        @(posedge clk);
        #1;
        if (!rst_n) mc1 = 0;
        else if (n1 != my1 && mc1 < 255) mc1++;
        my1 = n1;
        my8 = n8;
        check({tag, "_yq1"}, 32'(y_q1), 32'(my1));
        check({tag, "_yq8"}, 32'(y_q8), 32'(my8));
`ifdef MUX_CHANGE_CNT_EN
        check({tag, "_cnt1"}, 32'(cnt1), mc1);
`endif
    endtask

    initial begin
        logic [3:0] pat [4];
        logic [3:0] iso;
        rst_n = 1'b0;
        a1 = 4'b0100; sel1 = 2'b10;
        a8 = 32'h0;   sel8 = 2'b00;
        my1 = 1'b0; my8 = 8'h00; mc1 = 0;

        // reset state; y stays combinational under reset
        tick("reset");
        check("reset_y1_live", 32'(y1), 32'd1);
        tick("reset2");

        rst_n = 1'b1;
        // select sweep
        pat[0] = 4'b0000; pat[1] = 4'b1010; pat[2] = 4'b1111; pat[3] = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            a1 = pat[i]; sel1 = 2'(i);
            check_y("sweep");
            check("sweep_const", 32'(y1), (i == 0) ? 32'd0 : 32'd1);
            tick("sweep");
        end

        // lane isolation
        for (int r = 0; r < 2; r++) begin
            iso = (r == 0) ? 4'b0001 : 4'b1110;
            a1 = iso;
            for (int s = 0; s < 4; s++) begin
                sel1 = 2'(s);
                #1;
                check("iso", 32'(y1), (r == 0) ? ((s == 0) ? 32'd1 : 32'd0) : ((s == 0) ? 32'd0 : 32'd1));
            end
        end
        tick("iso");

        // latency, DATA_W=8
        a8 = 32'h0; sel8 = 2'b00;
        tick("lat_pre");
        a8 = {8'hDD, 8'hCC, 8'hBB, 8'hAA}; sel8 = 2'b10;
        #1;
        check("lat_y8", 32'(y8), 32'hCC);
        check("lat_yq8_before", 32'(y_q8), 32'h00);
        tick("lat");
        check("lat_yq8_after", 32'(y_q8), 32'hCC);

        // reset overrides the load, then y_q recaptures y
        rst_n = 1'b0;
        tick("rst_mid");
        check("rst_yq8", 32'(y_q8), 32'h00);
        check("rst_y8", 32'(y8), 32'hCC);
        rst_n = 1'b1;
        tick("rst_rel");
        check("rel_yq8", 32'(y_q8), 32'hCC);

        // simultaneous a/sel change
        a1 = 4'b0100; sel1 = 2'b10;
        tick("sim_pre");
        a1 = 4'b1000; sel1 = 2'b11;
        #1;
        check("sim_y1", 32'(y1), 32'd1);
        tick("sim");
        check("sim_yq1", 32'(y_q1), 32'd1);

        // randomized, including mid-cycle changes that must not reach y_q early
        for (int i = 0; i < 300; i++) begin
            rst_n = ($urandom_range(15) != 0);
            a1 = 4'($urandom); sel1 = 2'($urandom);
            a8 = $urandom;     sel8 = 2'($urandom);
            check_y("rnd");
            check("rnd_hold1", 32'(y_q1), 32'(my1));
            check("rnd_hold8", 32'(y_q8), 32'(my8));
            tick("rnd");
        end

`ifdef MUX_CHANGE_CNT_EN
        rst_n = 1'b0;
        tick("cnt_rst0");
        rst_n = 1'b1;
        a1 = 4'b0010;
        for (int i = 0; i < 300; i++) begin
            sel1 = 2'(i & 1);
            tick("cnt_tog");
        end
        check("cnt_sat", 32'(cnt1), 32'd255);
        rst_n = 1'b0;
        tick("cnt_rst");
        check("cnt_zero", 32'(cnt1), 32'd0);
        rst_n = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_4to1_using_2to1.md
MUX_4TO1_USING_2TO1 -- requirements
Module: mux_4to1_using_2to1

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter DATA_W, default 1: bit width of each of the four data lanes; legal range 1..32.
REQ-003 Port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 Port a, input, 4*DATA_W bits: lane k occupies a[k*DATA_W +: DATA_W], for k = 0..3.
REQ-006 Port sel, input, 2 bits: lane select.
REQ-007 Port y, output, DATA_W bits: combinational selected lane.
REQ-008 Port y_q, output, DATA_W bits: registered copy of y.

Function
REQ-009 y SHALL equal lane sel of a combinationally, with zero-cycle latency and no dependence on clk or rst_n.
REQ-010 Mapping SHALL be: sel=00 -> lane0, 01 -> lane1, 10 -> lane2, 11 -> lane3; with DATA_W=1, y = a[sel].
REQ-011 Selection SHALL be a two-level tree of three 2:1 muxes.
- Level 1: m0 = sel[0] ? lane1 : lane0; m1 = sel[0] ? lane3 : lane2.
- Level 2: y = sel[1] ? m1 : m0.
REQ-012 y_q SHALL load y on every rising clk edge where rst_n=1, giving exactly one cycle of latency.
REQ-013 Changes on a or sel that occur between clock edges SHALL propagate to y immediately and SHALL reach y_q only at the next edge.
REQ-014 Simultaneous changes on a and sel SHALL resolve as a single new selection; y shows no intermediate lane once settled.
REQ-015 The design SHALL contain no latches; every output SHALL be driven for all input values.

Reset
REQ-016 When rst_n=0 at a rising clk edge, y_q SHALL become all zeros; y SHALL remain combinational and unaffected by reset.
REQ-017 Reset asserted mid-operation SHALL override the y_q load at that edge.
REQ-018 On the first edge with rst_n=1 after reset, y_q SHALL capture the current y.

Configuration
REQ-019 Macro MUX_CHANGE_CNT_EN SHALL enable one optional feature.
REQ-020 With MUX_CHANGE_CNT_EN defined:
- Adds output chg_cnt, 8 bits.
- chg_cnt increments on each edge where the new y_q differs from the old y_q.
- chg_cnt saturates at 255.
- chg_cnt resets to 0 under rst_n=0.
REQ-021 Without MUX_CHANGE_CNT_EN, the chg_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-022 Shared package mux_pkg SHALL hold:
- Select encodings SEL_L0..SEL_L3 (2'b00..2'b11).
- Constant NUM_LANES=4.
- Constant CNT_W=8.
REQ-023 Sub-module mux_2to1 SHALL have:
- Parameter DATA_W.
- Ports d0, d1, s, y, implementing y = s ? d1 : d0.
- Exactly three instances in the top level.
REQ-024 Only the y_q register and the optional counter SHALL be clocked.

Verification
REQ-025 Select sweep (DATA_W=1, rst_n=1):
- a=0000, sel=00 -> y=0.
- a=1010, sel=01 -> y=1.
- a=1111, sel=10 -> y=1.
- a=1100, sel=11 -> y=1.
REQ-026 Lane isolation: a=0001, sweep sel 00..11 -> y = 1,0,0,0; repeat with a=1110 -> y = 0,1,1,1.
REQ-027 Latency (DATA_W=8):
- a={8'hDD,8'hCC,8'hBB,8'hAA}, sel=10 -> y=8'hCC immediately.
- y_q=8'hCC after the next edge, not before.
REQ-028 Reset:
- y_q=8'hCC, drive rst_n=0 for one edge -> y_q=8'h00 while y stays 8'hCC.
- Release rst_n -> y_q=8'hCC after one edge.
REQ-029 Counter (MUX_CHANGE_CNT_EN defined):
- Toggle sel between 00 and 01 with a=0010 for 300 edges -> chg_cnt saturates at 255.
- Assert rst_n=0 -> chg_cnt=0.
REQ-030 Simultaneous change: a=0100 with sel=10 changes at once to a=1000 with sel=11 -> y=1 and, after one edge, y_q=1.
